dma_mc_engine: RTL

//  Multi-channel memory-to-memory DMA engine sharing the single-port SRAM with the CTL core.
//  Per-channel src/dst/count registers, per-channel address modes (increment or fixed),

---
 rtl/dma_mc_engine.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dma_mc_engine.sv
// dma_mc_engine: multi-channel mem-to-mem DMA, round-robin per element, CPU-priority SRAM port
// Ports: clk/reset (async active-low); cpu_req; cfg_we/cfg_ch/cfg_src/cfg_dst/cfg_cnt/cfg_src_inc/cfg_dst_inc;
//   start/abort; poll_ch -> poll_cnt; ch_busy/ch_done/cfg_err status; sram_ADDR/DI/EN/WE out, sram_DO in.
module dma_mc_engine #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [CNT_W-1:0]  cfg_cnt,
  input  logic              cfg_src_inc,
  input  logic              cfg_dst_inc,
  input  logic              start,
  input  logic              abort,
  input  logic [CH_W-1:0]   poll_ch,
  output logic [CNT_W-1:0]  poll_cnt,
  output logic [NUM_CH-1:0] ch_busy,
  output logic [NUM_CH-1:0] ch_done,
  output logic              cfg_err,
  output logic [ADDR_W-1:0] sram_ADDR,
  output logic [DATA_W-1:0] sram_DI,
  output logic              sram_EN,
  output logic              sram_WE,
  input  logic [DATA_W-1:0] sram_DO
);
  typedef enum logic [1:0] {IDLE, RD, SMP, WR} state_t;
  state_t r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_src [NUM_CH];
  logic [ADDR_W-1:0] r_dst [NUM_CH];
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_sinc, r_dinc, r_busy, r_done;
  logic [NUM_CH-1:0] w_ld, w_start, w_zero, w_abt, w_fin, w_clr, w_done, w_avail;
  logic [CH_W-1:0]   r_act, r_rr, w_sel;
  logic [DATA_W-1:0] r_data, r_di;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic              r_err, r_stop, w_grant, w_act_abort, w_any, w_load_act;
  assign w_grant     = r_state == WR && !cpu_req;
  assign w_act_abort = abort && cfg_ch == r_act && r_state != IDLE;
  always_comb begin
    w_ld = '0;
    w_start = '0;
    w_zero = '0;
    w_abt = '0;
    w_fin = '0;
    w_clr = '0;
    w_done = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_abt[c]   = abort && cfg_ch == CH_W'(c);
      w_ld[c]    = cfg_we && cfg_ch == CH_W'(c) && !r_busy[c];
      w_start[c] = start && cfg_ch == CH_W'(c) && !r_busy[c] && !w_abt[c];
      w_zero[c]  = (w_ld[c] ? cfg_cnt : r_cnt[c]) == '0;
      // active channel stops at its grant on last element or pending/same-cycle abort
      w_fin[c]   = w_grant && r_act == CH_W'(c) && (r_cnt[c] == CNT_W'(1) || r_stop || w_abt[c]);
      w_clr[c]   = w_fin[c] || (w_abt[c] && !(r_state != IDLE && r_act == CH_W'(c)));
      w_done[c]  = (w_fin[c] && r_cnt[c] == CNT_W'(1) && !r_stop && !w_abt[c]) || (w_start[c] && w_zero[c]);
    end
  end
  assign w_avail = r_busy & ~w_clr;
  assign w_any   = |w_avail;
  // r_rr is the first index searched; lowest offset from it wins
  always_comb begin
    w_sel = r_rr;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (w_avail[(int'(r_rr) + i) % NUM_CH]) w_sel = CH_W'((int'(r_rr) + i) % NUM_CH);
  end
  assign w_load_act = (r_state == IDLE || w_grant) && w_any;
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    w_state_nxt = w_any ? RD : IDLE;
      RD:      w_state_nxt = cpu_req ? RD : SMP;
      SMP:     w_state_nxt = WR;
      default: w_state_nxt = cpu_req ? WR : w_any ? RD : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_state_nxt;
  assign w_addr    = r_state == WR ? r_dst[r_act] : r_src[r_act];
  assign sram_EN   = (r_state == RD || r_state == WR) && !cpu_req;
  assign sram_WE   = w_grant;
  assign sram_ADDR = sram_EN ? w_addr : r_addr;
  assign sram_DI   = sram_WE ? r_data : r_di;
  assign poll_cnt  = r_cnt[poll_ch];
  assign ch_busy   = r_busy;
  assign ch_done   = r_done;
  assign cfg_err   = r_err;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_src[c] <= '0;
        r_dst[c] <= '0;
        r_cnt[c] <= '0;
      end
      r_sinc <= '0;
      r_dinc <= '0;
      r_busy <= '0;
      r_done <= '0;
      r_err  <= 1'b0;
      r_stop <= 1'b0;
      r_act  <= '0;
      r_rr   <= '0;
      r_data <= '0;
      r_addr <= '0;
      r_di   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_ld[c]) begin
          r_src[c]  <= cfg_src;
          r_dst[c]  <= cfg_dst;
          r_cnt[c]  <= cfg_cnt;
          r_sinc[c] <= cfg_src_inc;
          r_dinc[c] <= cfg_dst_inc;
        end else if (w_grant && r_act == CH_W'(c)) begin
          r_src[c] <= r_src[c] + ADDR_W'(r_sinc[c]);
          r_dst[c] <= r_dst[c] + ADDR_W'(r_dinc[c]);
          r_cnt[c] <= r_cnt[c] - CNT_W'(1);
        end
      end
      r_busy <= w_avail | (w_start & ~w_zero);
      r_done <= w_done;
      r_err  <= (cfg_we || start) && r_busy[cfg_ch];
      r_stop <= !w_grant && (r_stop || w_act_abort);
      if (w_load_act) begin
        r_act <= w_sel;
        r_rr  <= w_sel == CH_W'(NUM_CH - 1) ? '0 : w_sel + 1'b1;
      end
      if (r_state == SMP) r_data <= sram_DO;
      if (sram_EN) r_addr <= w_addr;
      if (sram_WE) r_di <= r_data;
    end
  end
endmodule
